// File: rtl/cla_pipe_adder_pkg.sv
// rtl/cla_pipe_adder_pkg.sv - sizing helpers and parameter legality for cla_pipe_adder
package cla_pipe_adder_pkg;

  function automatic int calc_ngroups(input int width, input int group);
    return (group > 0) ? width / group : 0;
  endfunction

  function automatic int calc_gps(input int ngroups, input int stages);
    return (stages > 0) ? ngroups / stages : 0;
  endfunction

  // Stage k starts with k*GPS*GROUP sum bits done; everything above is still skewed operand.
  function automatic int stage_lo(input int k, input int gps, input int group);
    return k * gps * group;
  endfunction

  function automatic bit params_legal(input int width, input int group, input int stages);
    int ng;
    ng = calc_ngroups(width, group);
    return (width > 0) && (group > 0) && (width % group == 0) &&
           (stages >= 1) && (stages <= ng) && (ng % stages == 0);
  endfunction

endpackage

// File: rtl/cla_pipe_adder_group.sv
// rtl/cla_pipe_adder_group.sv - combinational GROUP-bit lookahead slice with group G/P
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             c_in,
  output logic [GROUP-1:0] s,
  output logic             g,
  output logic             p
);
  logic [GROUP-1:0] gen;
  logic [GROUP-1:0] prop;
  logic [GROUP-1:0] c;

  assign gen  = a & b;
  assign prop = a ^ b;
  assign p    = &prop;

  // Group generate never looks at c_in, so the upper lookahead level cannot loop through it.
  always_comb begin
    g = 1'b0;
    for (int i = 0; i < GROUP; i++) g = gen[i] | (prop[i] & g);
  end

  always_comb begin
    c    = '0;
    c[0] = c_in;
    for (int i = 1; i < GROUP; i++) c[i] = gen[i-1] | (prop[i-1] & c[i-1]);
  end

  assign s = prop ^ c;

endmodule

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined carry-lookahead adder/subtractor with valid/ready handshake
module cla_pipe_adder
  import cla_pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NGROUPS = calc_ngroups(WIDTH, GROUP);
  localparam int GPS     = calc_gps(NGROUPS, STAGES);
  localparam int SW      = GPS * GROUP;

  if (!params_legal(WIDTH, GROUP, STAGES)) begin : g_illegal
    $error("cla_pipe_adder: illegal WIDTH=%0d GROUP=%0d STAGES=%0d", WIDTH, GROUP, STAGES);
  end

  logic              adv;
  logic [STAGES-1:0] vld_q;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;
  logic              ovf_q;
  logic              zero_q;

  assign out_valid = vld_q[STAGES-1];
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) vld_q[k] <= vld_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO = stage_lo(k, GPS, GROUP);
    localparam int HI = WIDTH - LO;

    logic [HI-1:0]    a_in;
    logic [HI-1:0]    b_in;
    logic             c_in;
    logic [SW-1:0]    s_stg;
    logic [LO+SW-1:0] s_all;
    logic [GPS-1:0]   grp_g;
    logic [GPS-1:0]   grp_p;
    logic [GPS:0]     grp_c;

    if (k == 0) begin : g_head
      // Subtraction folds in here as a + ~b + 1; downstream stages only ever add.
      assign a_in  = a;
      assign b_in  = sub ? ~b : b;
      assign c_in  = sub | cin;
      assign s_all = s_stg;
    end else begin : g_tail
      assign a_in  = g_stg[k-1].g_reg.a_q;
      assign b_in  = g_stg[k-1].g_reg.b_q;
      assign c_in  = g_stg[k-1].g_reg.c_q;
      assign s_all = {s_stg, g_stg[k-1].g_reg.s_q};
    end

    for (genvar j = 0; j < GPS; j++) begin : g_grp
      cla_group #(.GROUP(GROUP)) u_grp (
        .a    (a_in[j*GROUP +: GROUP]),
        .b    (b_in[j*GROUP +: GROUP]),
        .c_in (grp_c[j]),
        .s    (s_stg[j*GROUP +: GROUP]),
        .g    (grp_g[j]),
        .p    (grp_p[j])
      );
    end

    // Second-level lookahead: each group carry is a flat sum of products from c_in.
    always_comb begin
      logic carry;
      logic pchain;
      grp_c    = '0;
      grp_c[0] = c_in;
      for (int j = 0; j < GPS; j++) begin
        carry  = 1'b0;
        pchain = 1'b1;
        for (int i = j; i >= 0; i--) begin
          carry  = carry | (pchain & grp_g[i]);
          pchain = pchain & grp_p[i];
        end
        grp_c[j+1] = carry | (pchain & c_in);
      end
    end

    if (k < STAGES - 1) begin : g_reg
      logic [HI-SW-1:0] a_q;
      logic [HI-SW-1:0] b_q;
      logic [LO+SW-1:0] s_q;
      logic             c_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
          c_q <= 1'b0;
        end else if (adv) begin
          a_q <= a_in[HI-1:SW];
          b_q <= b_in[HI-1:SW];
          s_q <= s_all;
          c_q <= grp_c[GPS];
        end
      end
    end else begin : g_last
      logic c_msb;

      // Carry into the MSB falls out of its sum bit: s = a ^ b ^ c.
      assign c_msb = s_stg[SW-1] ^ a_in[HI-1] ^ b_in[HI-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sum_q  <= '0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          sum_q  <= s_all;
          cout_q <= grp_c[GPS];
          ovf_q  <= c_msb ^ grp_c[GPS];
          zero_q <= ~|s_all;
        end
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - self-checking bench for cla_pipe_adder
module tb_cla_pipe_adder;

  typedef struct packed {
    logic [63:0] s;
    logic        c;
    logic        o;
    logic        z;
  } res_t;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        c;
    logic        o;
    logic        z;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic, borrow as a compare, overflow from operand/result signs.
  function automatic res_t gold(input int w, input logic [63:0] x, input logic [63:0] y,
                                input logic ci, input logic sb);
    logic [64:0] full;
    logic [63:0] mask;
    res_t        r;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    x    = x & mask;
    y    = y & mask;
    if (sb) begin
      r.s = (x - y) & mask;
      r.c = (x >= y);
      r.o = (x[w-1] != y[w-1]) && (r.s[w-1] != x[w-1]);
    end else begin
      full = {1'b0, x} + {1'b0, y} + {64'd0, ci};
      r.s  = full[63:0] & mask;
      r.c  = full[w];
      r.o  = (x[w-1] == y[w-1]) && (r.s[w-1] != x[w-1]);
    end
    r.z = (r.s == 64'd0);
    return r;
  endfunction

  logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
  logic [31:0] a, b, sum;

  cla_pipe_adder u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  function automatic res_t dut_res();
    res_t r;
    r.s = {32'd0, sum};
    r.c = cout;
    r.o = ovf;
    r.z = zero;
    return r;
  endfunction

  task automatic apply_vec(input vec_t v);
    int   lat;
    res_t exp;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({v.name, "_latency"}, lat, 2);
    exp.s = {32'd0, v.s};
    exp.c = v.c;
    exp.o = v.o;
    exp.z = v.z;
    check(v.name, dut_res(), exp);
  endtask

  // Parameter sweep: independent instances fed random beats with out_ready tied high.
  logic rst_s;
  initial begin
    rst_s = 1'b1;
    #22 rst_s = 1'b0;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    localparam int PW = (gi == 2) ? 64 : 16;
    localparam int PG = (gi == 2) ? 8 : 4;
    localparam int PS = (gi == 0) ? 1 : 4;

    logic          iv, ir, ov, ci, sb, co, of, ze;
    logic [PW-1:0] sa, sbb, ss;
    bit            done = 1'b0;

    cla_pipe_adder #(.WIDTH(PW), .GROUP(PG), .STAGES(PS)) u_sw (
      .clk       (clk),
      .rst       (rst_s),
      .in_valid  (iv),
      .in_ready  (ir),
      .a         (sa),
      .b         (sbb),
      .cin       (ci),
      .sub       (sb),
      .out_valid (ov),
      .out_ready (1'b1),
      .sum       (ss),
      .cout      (co),
      .ovf       (of),
      .zero      (ze)
    );

    initial begin
      res_t        q[$];
      int          acc[$];
      res_t        e, act;
      int          sent, got, lat;
      logic [63:0] ra, rb;
      iv = 1'b0; sa = '0; sbb = '0; ci = 1'b0; sb = 1'b0;
      sent = 0; got = 0;
      @(negedge clk);
      while (rst_s) @(negedge clk);
      for (int t = 0; t < 4000 && (sent < 1000 || q.size() != 0); t++) begin
        @(negedge clk);
        if (ov) begin
          act.s = 64'(ss); act.c = co; act.o = of; act.z = ze;
          if (q.size() == 0) begin
            check($sformatf("sweep%0d_spurious", gi), 1, 0);
          end else begin
            e   = q.pop_front();
            lat = cyc - acc.pop_front();
            check($sformatf("sweep%0d_beat%0d", gi, got), {act, lat}, {e, PS});
          end
          got++;
        end
        iv = 1'b0;
        if (sent < 1000 && $urandom_range(9) != 0) begin
          ra = {$urandom, $urandom};
          rb = {$urandom, $urandom};
          ci = 1'($urandom_range(1));
          sb = 1'($urandom_range(1));
          case ($urandom_range(7))
            0: begin ra = '1; rb = 64'd1; sb = 1'b0; ci = 1'b0; end
            1: begin ra = '1; rb = 64'd0; sb = 1'b0; ci = 1'b1; end
            2: begin rb = ra; sb = 1'b1; end
            default: ;
          endcase
          sa  = ra[PW-1:0];
          sbb = rb[PW-1:0];
          iv  = 1'b1;
        end
        #1;
        if (iv && ir) begin
          q.push_back(gold(PW, 64'(sa), 64'(sbb), ci, sb));
          acc.push_back(cyc);
          sent++;
        end
      end
      check($sformatf("sweep%0d_drained", gi), {sent, got, q.size()}, {32'd1000, 32'd1000, 32'd0});
      done = 1'b1;
    end
  end

  vec_t vecs[9];

  initial begin
    res_t        q[$];
    res_t        e, snap;
    logic [67:0] prev;
    vec_t        pv;
    int          sent, got, stale, fin;
    bit          have;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    vecs[0] = '{"add_carry16",  32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"sub_equal",    32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{"sub_borrow",   32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{"add_ovf_pos",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{"add_ovf_neg",  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{"add_cin_wrap", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{"sub_cin_ign",  32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{"sub_ovf_min",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{"add_mixed",    32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0};

    #12;
    check("reset_outputs", {out_valid, sum, cout, ovf, zero}, '0);
    #10 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 9; i++) apply_vec(vecs[i]);

    // Backpressure: 8 back-to-back beats, out_ready low for cycles 3..7.
    sent = 0; got = 0; have = 1'b0; prev = '0;
    for (int t = 0; t < 60 && got < 8; t++) begin
      @(negedge clk);
      out_ready = !(t >= 3 && t < 8);
      if (!have && sent < 8) begin
        a = $urandom; b = $urandom;
        cin = 1'($urandom_range(1));
        sub = 1'($urandom_range(1));
        have = 1'b1;
      end
      in_valid = have;
      #1;
      snap = dut_res();
      if (t >= 3 && t < 8) check($sformatf("bp_in_ready_t%0d", t), in_ready, 1'b0);
      if (t >= 4 && t < 8) check($sformatf("bp_hold_t%0d", t), {out_valid, snap}, {1'b1, prev[66:0]});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("bp_spurious", 1, 0);
        end else begin
          e = q.pop_front();
          check($sformatf("bp_beat%0d", got), snap, e);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(gold(32, {32'd0, a}, {32'd0, b}, cin, sub));
        sent++;
        have = 1'b0;
      end
      prev = {out_valid, snap};
    end
    in_valid = 1'b0;
    check("bp_counts", {sent, got, q.size()}, {32'd8, 32'd8, 32'd0});
    stale = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("bp_no_duplicate", stale, 0);

    // Reset with two beats in flight.
    @(negedge clk);
    a = 32'd1; b = 32'd2; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    a = 32'd3; b = 32'd4;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1 check("mid_first_beat_out", {out_valid, sum}, {1'b1, 32'd3});
    #1 rst = 1'b1;
    #1 check("rst_async_clear", {out_valid, sum, cout, ovf, zero}, '0);
    @(posedge clk);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("rst_no_stale", stale, 0);
    pv = '{"post_rst", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    apply_vec(pv);

    fin = 0;
    for (int i = 0; i < 20000 && fin != 3; i++) begin
      @(negedge clk);
      fin = int'(g_sweep[0].done) + int'(g_sweep[1].done) + int'(g_sweep[2].done);
    end
    check("sweep_complete", fin, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
